// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one instruction-bus request
// at a time and buffers a single fetched instruction for decode.
//
// state | meaning
// ------+-----------------------------------------------------------
// START | first cycle after reset, no request yet
// REQ   | request for ireq_addr outstanding, response will be used
// HOLD  | instruction buffered, waiting for decode to accept
// KILL  | request still outstanding but its response will be dropped
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        d_ready,
  output logic        busy
);

  localparam logic [63:0] RESET_PC_AL = {RESET_PC[63:2], 2'b00};

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] addr_nxt;
  logic [63:0] f_pc_nxt;
  logic [31:0] f_instr_nxt;
  logic        f_valid_nxt;
  logic [63:0] redir_pc;
  logic        redirect_lsb_unused;

  // Targets are word aligned; the low bits of a redirect are simply discarded.
  assign redir_pc            = {redirect_pc[63:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign ireq_valid = (state == ST_REQ) || (state == ST_KILL);
  assign busy       = ireq_valid;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    addr_nxt    = ireq_addr;
    f_pc_nxt    = f_pc;
    f_instr_nxt = f_instr;
    f_valid_nxt = f_valid;
    case (state)
      ST_START: begin
        state_nxt = ST_REQ;
        addr_nxt  = pc;
      end
      ST_REQ: begin
        if (redirect_valid && !iresp_data_ok) begin
          state_nxt = ST_KILL;
          pc_nxt    = redir_pc;
        end else if (redirect_valid && iresp_data_ok) begin
          pc_nxt    = redir_pc;
          addr_nxt  = redir_pc;
        end else if (iresp_data_ok) begin
          state_nxt   = ST_HOLD;
          f_instr_nxt = iresp_data;
          f_pc_nxt    = ireq_addr;
          f_valid_nxt = 1'b1;
          pc_nxt      = ireq_addr + 64'd4;
        end
      end
      ST_HOLD: begin
        // A redirect squashes the buffered instruction even if decode is ready.
        if (redirect_valid) begin
          state_nxt   = ST_REQ;
          f_valid_nxt = 1'b0;
          pc_nxt      = redir_pc;
          addr_nxt    = redir_pc;
        end else if (d_ready) begin
          state_nxt   = ST_REQ;
          f_valid_nxt = 1'b0;
          addr_nxt    = pc;
        end
      end
      ST_KILL: begin
        if (redirect_valid) begin
          pc_nxt = redir_pc;
        end
        if (iresp_data_ok) begin
          state_nxt = ST_REQ;
          addr_nxt  = redirect_valid ? redir_pc : pc;
        end
      end
      default: begin
        state_nxt = ST_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_START;
      pc        <= RESET_PC_AL;
      ireq_addr <= RESET_PC_AL;
      f_pc      <= 64'd0;
      f_instr   <= 32'd0;
      f_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ireq_addr <= addr_nxt;
      f_pc      <= f_pc_nxt;
      f_instr   <= f_instr_nxt;
      f_valid   <= f_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        d_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
    .d_ready        (d_ready),
    .busy           (busy)
  );

  // Transaction-level model: a fetcher with one bus slot that may be marked
  // stale by a redirect, and a one-entry instruction buffer.
  bit          m_first;
  bit          m_on_bus;
  bit          m_stale;
  logic [63:0] m_bus_addr;
  logic [63:0] m_next_pc;
  bit          m_buf_full;
  logic [63:0] m_buf_pc;
  logic [31:0] m_buf_instr;

  always @(posedge clk) begin
    logic [63:0] target;
    target = redirect_pc & ~64'd3;
    if (!reset) begin
      m_first     = 1'b1;
      m_on_bus    = 1'b0;
      m_stale     = 1'b0;
      m_bus_addr  = RST_PC;
      m_next_pc   = RST_PC;
      m_buf_full  = 1'b0;
      m_buf_pc    = 64'd0;
      m_buf_instr = 32'd0;
    end else if (m_first) begin
      m_first    = 1'b0;
      m_on_bus   = 1'b1;
      m_bus_addr = m_next_pc;
    end else if (m_on_bus) begin
      if (redirect_valid) m_next_pc = target;
      if (iresp_data_ok) begin
        if (m_stale || redirect_valid) begin
          m_stale    = 1'b0;
          m_bus_addr = m_next_pc;
        end else begin
          m_on_bus    = 1'b0;
          m_buf_full  = 1'b1;
          m_buf_pc    = m_bus_addr;
          m_buf_instr = iresp_data;
          m_next_pc   = m_bus_addr + 64'd4;
        end
      end else if (redirect_valid) begin
        m_stale = 1'b1;
      end
    end else if (m_buf_full && (redirect_valid || d_ready)) begin
      m_buf_full = 1'b0;
      if (redirect_valid) m_next_pc = target;
      m_on_bus   = 1'b1;
      m_bus_addr = m_next_pc;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model ireq_valid", {63'd0, ireq_valid}, {63'd0, m_on_bus});
      chk("model busy",       {63'd0, busy},       {63'd0, m_on_bus});
      chk("model ireq_addr",  ireq_addr,           m_bus_addr);
      chk("model f_valid",    {63'd0, f_valid},    {63'd0, m_buf_full});
      chk("model f_pc",       f_pc,                m_buf_pc);
      chk("model f_instr",    {32'd0, f_instr},    {32'd0, m_buf_instr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    iresp_data_ok  = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    d_ready        = 1'b0;

    step();
    cmp_en = 1'b1;
    step();
    chk("rst ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst ireq_addr",  ireq_addr, RST_PC);
    chk("rst f_valid",    {63'd0, f_valid}, 64'd0);
    chk("rst f_pc",       f_pc, 64'd0);
    chk("rst f_instr",    {32'd0, f_instr}, 64'd0);

    reset = 1'b1;
    chk("cycle1 ireq_valid", {63'd0, ireq_valid}, 64'd0);
    step();
    chk("cycle2 ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("cycle2 ireq_addr",  ireq_addr, 64'h8000_0000);

    // zero-wait memory, decode always ready: one instruction per 2 cycles
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("seq ireq_addr", ireq_addr, 64'h8000_0000 + 64'(4 * i));
      iresp_data_ok = 1'b1;
      iresp_data    = 32'h1000_0000 + 32'(i);
      step();
      clear_pulses();
      chk("seq f_valid", {63'd0, f_valid}, 64'd1);
      chk("seq f_pc",    f_pc, 64'h8000_0000 + 64'(4 * i));
      chk("seq f_instr", {32'd0, f_instr}, 64'h1000_0000 + 64'(i));
      step();
    end

    // back-pressure in HOLD
    d_ready       = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hCAFE_0001;
    step();
    clear_pulses();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp f_valid",    {63'd0, f_valid}, 64'd1);
      chk("bp f_pc",       f_pc, 64'h8000_000C);
      chk("bp f_instr",    {32'd0, f_instr}, 64'hCAFE_0001);
      chk("bp ireq_valid", {63'd0, ireq_valid}, 64'd0);
    end
    d_ready = 1'b1;
    step();
    chk("bp next addr", ireq_addr, 64'h8000_0010);

    // redirect while the request waits 3 cycles
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    clear_pulses();
    for (int i = 0; i < 3; i++) begin
      chk("kill addr held", ireq_addr, 64'h8000_0010);
      chk("kill f_valid",   {63'd0, f_valid}, 64'd0);
      step();
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_0000;
    step();
    clear_pulses();
    chk("kill f_valid after ok", {63'd0, f_valid}, 64'd0);
    chk("kill next addr",        ireq_addr, 64'h8000_0100);

    // redirect together with data_ok
    iresp_data_ok  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    clear_pulses();
    chk("redir+ok f_valid", {63'd0, f_valid}, 64'd0);
    chk("redir+ok addr",    ireq_addr, 64'h8000_0200);

    // redirect together with d_ready in HOLD, unaligned target
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0200;
    step();
    clear_pulses();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    step();
    clear_pulses();
    chk("redir+rdy f_valid", {63'd0, f_valid}, 64'd0);
    chk("redir+rdy addr",    ireq_addr, 64'h8000_0100);

    // wrap around the top of the address space
    iresp_data_ok  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_pulses();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h7777_7777;
    step();
    clear_pulses();
    chk("wrap f_pc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap addr", ireq_addr, 64'd0);

    // reset mid-REQ, stray response in START ignored, then reset mid-HOLD
    reset = 1'b0;
    step();
    chk("rst mid-req ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst mid-req busy",       {63'd0, busy}, 64'd0);
    chk("rst mid-req addr",       ireq_addr, RST_PC);
    reset         = 1'b1;
    iresp_data_ok = 1'b1;
    step();
    clear_pulses();
    chk("stray ok f_valid", {63'd0, f_valid}, 64'd0);
    chk("stray ok addr",    ireq_addr, RST_PC);
    d_ready       = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h5555_AAAA;
    step();
    clear_pulses();
    reset = 1'b0;
    step();
    chk("rst mid-hold f_valid", {63'd0, f_valid}, 64'd0);
    chk("rst mid-hold f_pc",    f_pc, 64'd0);
    chk("rst mid-hold f_instr", {32'd0, f_instr}, 64'd0);
    reset = 1'b1;

    // randomized traffic; responses only while the model has a bus slot open
    for (int c = 0; c < 4000; c++) begin
      reset          = ($urandom_range(199) != 0);
      redirect_valid = ($urandom_range(9) == 0);
      case ($urandom_range(3))
        0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        default: redirect_pc = {32'h8000_0000, $urandom()};
      endcase
      iresp_data_ok = m_on_bus && ($urandom_range(9) < 4);
      iresp_data    = $urandom();
      d_ready       = ($urandom_range(9) < 6);
      step();
    end
    clear_pulses();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
